// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants, state codes and keep-mask helper for fifo_rd_packer.
// Optional pop counter is enabled by defining FIFO_RD_PACKER_CNT_EN.
package fifo_rd_pkg;

   localparam int DEF_DSIZE     = 8;
   localparam int DEF_OUT_BYTES = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   // Mask with the low n bits set; n ranges 0..8.
   function automatic logic [7:0] keep_mask(input logic [3:0] n);
      return 8'((9'd1 << n) - 9'd1);
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Packed-word valid/ready stream between fifo_rd_packer and its sink.
// Optional pop counter is enabled by defining FIFO_RD_PACKER_CNT_EN.
interface fifo_rd_packer_if #(
   parameter int DSIZE     = fifo_rd_pkg::DEF_DSIZE,
   parameter int OUT_BYTES = fifo_rd_pkg::DEF_OUT_BYTES
);

   logic [DSIZE*OUT_BYTES-1:0] out_data;
   logic [OUT_BYTES-1:0]       out_keep;
   logic                       out_last;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      output out_data,
      output out_keep,
      output out_last,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_keep,
      input  out_last,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/fifo_rd_packer_outreg.sv
// One-entry valid/ready output register for the packed word stream.
// Optional pop counter is enabled by defining FIFO_RD_PACKER_CNT_EN.
module fifo_rd_outreg #(
   parameter int DSIZE     = 8,
   parameter int OUT_BYTES = 4
) (
   input  logic                       rclk,
   input  logic                       rrst_n,
   input  logic                       load,
   input  logic [DSIZE*OUT_BYTES-1:0] ld_data,
   input  logic [OUT_BYTES-1:0]       ld_keep,
   input  logic                       ld_last,
   output logic                       slot_free,
   fifo_rd_packer_if.master           o
);

   // A word may load while the current one is being accepted.
   assign slot_free = !o.out_valid || o.out_ready;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         o.out_valid <= 1'b0;
         o.out_data  <= '0;
         o.out_keep  <= '0;
         o.out_last  <= 1'b0;
      end else if (load) begin
         o.out_valid <= 1'b1;
         o.out_data  <= ld_data;
         o.out_keep  <= ld_keep;
         o.out_last  <= ld_last;
      end else if (o.out_ready) begin
         o.out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer packing OUT_BYTES entries into one stream word.
// Optional pop counter is enabled by defining FIFO_RD_PACKER_CNT_EN.
module fifo_rd_packer
   import fifo_rd_pkg::*;
#(
   parameter int DSIZE     = DEF_DSIZE,
   parameter int OUT_BYTES = DEF_OUT_BYTES,
   parameter int IDXW      = $clog2(OUT_BYTES)
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic             flush,
   fifo_rd_packer_if.master o,
`ifdef FIFO_RD_PACKER_CNT_EN
   input  logic             cnt_clr,
   output logic [31:0]      pop_cnt,
`endif
   output logic             busy
);

   localparam int W  = DSIZE * OUT_BYTES;
   localparam int PW = W - DSIZE;
   localparam logic [IDXW-1:0] LAST = IDXW'(OUT_BYTES - 1);

   logic [1:0]           state;
   logic [IDXW-1:0]      idx;
   logic [PW-1:0]        pack;
   logic                 slot_free;
   logic                 at_last;
   logic                 flush_pend;
   logic                 full_load;
   logic                 part_load;
   logic                 load;
   logic                 ld_last;
   logic [W-1:0]         part;
   logic [W-1:0]         ld_data;
   logic [OUT_BYTES-1:0] ld_keep;

   assign flush_pend = (state == ST_FLUSH);
   assign at_last    = (idx == LAST);

   // The last slot is only popped when the word can leave immediately.
   assign rinc = rrst_n && !rempty && !flush_pend
              && (!at_last || slot_free);

   assign full_load = rinc && at_last;
   assign part_load = flush_pend && slot_free;
   assign load      = full_load || part_load;

   always_comb begin
      part = '0;
      for (int k = 0; k < OUT_BYTES - 1; k++) begin
         if (IDXW'(k) < idx)
            part[k*DSIZE +: DSIZE] = pack[k*DSIZE +: DSIZE];
      end
   end

   // The final entry bypasses pack and goes straight into the word.
   always_comb begin
      ld_data = part;
      ld_keep = OUT_BYTES'(keep_mask(4'(idx)));
      ld_last = 1'b1;
      if (full_load) begin
         ld_data = {rdata, pack};
         ld_keep = '1;
         ld_last = flush;
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         pack  <= '0;
      end else if (part_load) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else if (rinc) begin
         if (at_last) begin
            state <= ST_IDLE;
            idx   <= '0;
         end else begin
            pack[idx*DSIZE +: DSIZE] <= rdata;
            idx   <= idx + IDXW'(1);
            state <= flush ? ST_FLUSH : ST_FILL;
         end
      end else if (flush && state == ST_FILL) begin
         state <= ST_FLUSH;
      end
   end

   fifo_rd_outreg #(
      .DSIZE     (DSIZE),
      .OUT_BYTES (OUT_BYTES)
   ) u_outreg (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .load      (load),
      .ld_data   (ld_data),
      .ld_keep   (ld_keep),
      .ld_last   (ld_last),
      .slot_free (slot_free),
      .o         (o)
   );

   assign busy = (idx != '0) || o.out_valid;

`ifdef FIFO_RD_PACKER_CNT_EN
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)
         pop_cnt <= '0;
      else if (cnt_clr)
         pop_cnt <= {31'd0, rinc};
      else if (rinc)
         pop_cnt <= pop_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed plus random bench for fifo_rd_packer against a queue-based model.
// Define FIFO_RD_PACKER_CNT_EN to also exercise the pop counter.
module tb_fifo_rd_packer;

   localparam int N = 4;

   logic       rclk   = 1'b0;
   logic       rrst_n = 1'b0;
   logic       rempty = 1'b1;
   logic       flush  = 1'b0;
   logic [7:0] rdata  = 8'h00;
   logic       rinc;
   logic       busy;

   always #5 rclk = ~rclk;

   fifo_rd_packer_if #(.DSIZE(8), .OUT_BYTES(N)) s();

`ifdef FIFO_RD_PACKER_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [31:0] pop_cnt;
   int unsigned mcnt = 0;
`endif

   fifo_rd_packer #(.DSIZE(8), .OUT_BYTES(N)) dut (
      .rclk    (rclk),
      .rrst_n  (rrst_n),
      .rempty  (rempty),
      .rdata   (rdata),
      .rinc    (rinc),
      .flush   (flush),
      .o       (s),
`ifdef FIFO_RD_PACKER_CNT_EN
      .cnt_clr (cnt_clr),
      .pop_cnt (pop_cnt),
`endif
      .busy    (busy)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  fq[$];
   logic [7:0]  cur[$];
   logic [31:0] got_d[$];
   logic [3:0]  got_k[$];
   logic        got_l[$];

   logic        mvalid = 1'b0;
   logic        mlast  = 1'b0;
   logic        mpend  = 1'b0;
   logic [31:0] mdata  = '0;
   logic [3:0]  mkeep  = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cur_word();
      logic [31:0] w;
      w = '0;
      foreach (cur[i]) w[i*8 +: 8] = cur[i];
      return w;
   endfunction

   function automatic void model_reset();
      cur.delete();
      mvalid = 1'b0;
      mdata  = '0;
      mkeep  = '0;
      mlast  = 1'b0;
      mpend  = 1'b0;
`ifdef FIFO_RD_PACKER_CNT_EN
      mcnt = 0;
`endif
   endfunction

   // One clock: drive, check before the edge, then advance the model.
   task automatic cyc(input logic fl, input logic rdy);
      logic        mr, sf, ld, nl;
      logic [31:0] nd;
      logic [3:0]  nk;
      flush       = fl;
      s.out_ready = rdy;
      rempty      = (fq.size() == 0);
      rdata       = rempty ? 8'h00 : fq[0];
      sf = !mvalid || rdy;
      mr = !rempty && !mpend && (cur.size() != N - 1 || sf);
      #1;
      chk("rinc", 32'(rinc), 32'(mr));
      chk("out_valid", 32'(s.out_valid), 32'(mvalid));
      chk("busy", 32'(busy), 32'(cur.size() > 0 || mvalid));
      if (mvalid) begin
         chk("out_data", s.out_data, mdata);
         chk("out_keep", 32'(s.out_keep), 32'(mkeep));
         chk("out_last", 32'(s.out_last), 32'(mlast));
      end
`ifdef FIFO_RD_PACKER_CNT_EN
      chk("pop_cnt", pop_cnt, mcnt);
      if (cnt_clr) mcnt = mr ? 1 : 0;
      else if (mr) mcnt = mcnt + 1;
`endif
      if (s.out_valid && rdy) begin
         got_d.push_back(s.out_data);
         got_k.push_back(s.out_keep);
         got_l.push_back(s.out_last);
      end
      @(posedge rclk);
      ld = 1'b0;
      nd = '0;
      nk = '0;
      nl = 1'b0;
      if (mpend && sf) begin
         nd = cur_word();
         nk = 4'((1 << cur.size()) - 1);
         nl = 1'b1;
         ld = 1'b1;
         cur.delete();
         mpend = 1'b0;
      end else if (mr) begin
         cur.push_back(fq.pop_front());
         if (cur.size() == N) begin
            nd = cur_word();
            nk = 4'hF;
            nl = fl;
            ld = 1'b1;
            cur.delete();
         end else if (fl) begin
            mpend = 1'b1;
         end
      end else if (fl && cur.size() > 0) begin
         mpend = 1'b1;
      end
      if (ld) begin
         mvalid = 1'b1;
         mdata  = nd;
         mkeep  = nk;
         mlast  = nl;
      end else if (rdy) begin
         mvalid = 1'b0;
      end
      #1;
      flush = 1'b0;
   endtask

   initial begin
      s.out_ready = 1'b1;
      // Preload the first word while reset is held.
      fq = '{8'h11, 8'h22, 8'h33, 8'h44};
      rempty = 1'b0;
      rdata  = 8'h11;
      @(posedge rclk);
      @(posedge rclk);
      #1;
      chk("rst_rinc", 32'(rinc), 32'd0);
      chk("rst_valid", 32'(s.out_valid), 32'd0);
      chk("rst_data", s.out_data, 32'd0);
      chk("rst_keep", 32'(s.out_keep), 32'd0);
      chk("rst_last", 32'(s.out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_RD_PACKER_CNT_EN
      chk("rst_cnt", pop_cnt, 32'd0);
`endif
      rrst_n = 1'b1;

      // Full word with sink always ready.
      repeat (6) cyc(1'b0, 1'b1);
      chk("t1_words", 32'(got_d.size()), 32'd1);
      chk("t1_data", got_d[0], 32'h44332211);
      chk("t1_keep", 32'(got_k[0]), 32'hF);
      chk("t1_last", 32'(got_l[0]), 32'd0);

      // Backpressure: second word waits for the slot.
      for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
      repeat (10) cyc(1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b1);
      chk("t2_words", 32'(got_d.size()), 32'd3);
      chk("t2_data0", got_d[1], 32'h04030201);
      chk("t2_data1", got_d[2], 32'h08070605);

      // Partial flush.
      fq.push_back(8'hAA);
      fq.push_back(8'hBB);
      repeat (3) cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b1);
      chk("t3_words", 32'(got_d.size()), 32'd4);
      chk("t3_data", got_d[3], 32'h0000BBAA);
      chk("t3_keep", 32'(got_k[3]), 32'h3);
      chk("t3_last", 32'(got_l[3]), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);

      // Flush while idle and empty is ignored.
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b1);
      chk("t4_words", 32'(got_d.size()), 32'd4);

      // Flush on the completing pop.
      for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
      repeat (3) cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      repeat (4) cyc(1'b0, 1'b1);
      chk("t5_words", 32'(got_d.size()), 32'd5);
      chk("t5_data", got_d[4], 32'h04030201);
      chk("t5_keep", 32'(got_k[4]), 32'hF);
      chk("t5_last", 32'(got_l[4]), 32'd1);

      // Reset with a held word and two packed entries.
      for (int i = 1; i <= 6; i++) fq.push_back(8'(8'h50 + i));
      repeat (8) cyc(1'b0, 1'b0);
      chk("t6_pre_valid", 32'(s.out_valid), 32'd1);
      rrst_n = 1'b0;
      model_reset();
      fq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      rempty = 1'b0;
      rdata  = 8'hA0;
      #1;
      chk("t6_valid", 32'(s.out_valid), 32'd0);
      chk("t6_keep", 32'(s.out_keep), 32'd0);
      chk("t6_rinc", 32'(rinc), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
`ifdef FIFO_RD_PACKER_CNT_EN
      chk("t6_cnt", pop_cnt, 32'd0);
`endif
      #2;
      rrst_n = 1'b1;
      repeat (6) cyc(1'b0, 1'b1);
      chk("t6_words", 32'(got_d.size()), 32'd6);
      chk("t6_data", got_d[5], 32'hA3A2A1A0);
      chk("t6_wkeep", 32'(got_k[5]), 32'hF);

`ifdef FIFO_RD_PACKER_CNT_EN
      // Clear coinciding with a pop leaves a count of one.
      fq.push_back(8'h77);
      cnt_clr = 1'b1;
      cyc(1'b0, 1'b1);
      cnt_clr = 1'b0;
      #1;
      chk("clr_pop_cnt", pop_cnt, 32'd1);
`endif

      // Random traffic, flushes and backpressure.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) != 0 && fq.size() < 16)
            fq.push_back(8'($urandom));
`ifdef FIFO_RD_PACKER_CNT_EN
         cnt_clr = ($urandom_range(0, 31) == 0);
`endif
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      end
`ifdef FIFO_RD_PACKER_CNT_EN
      cnt_clr = 1'b0;
`endif
      repeat (30) cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);
      repeat (4) cyc(1'b0, 1'b1);
      chk("drain_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer for the async FIFO. Sits in the rclk domain, attached to the FIFO read port (rinc/rempty/rdata).
- Pops DSIZE-bit entries and packs OUT_BYTES of them little-endian into one wide word.
- Presents each word on a valid/ready stream. A flush request forces a partial word out with a keep mask.

Parameters:
- DSIZE, 8, width of one FIFO entry (matches FIFO DSIZE).
- OUT_BYTES, 4, entries per output word (2..8).
- IDXW, $clog2(OUT_BYTES), width of the pack index.

Ports:
- rclk  in  1  read-domain clock; all logic on rising edge.
- rrst_n  in  1  reset, asynchronous, active-low.
- rempty  in  1  FIFO empty flag; rdata is valid when low.
- rdata  in  DSIZE  FIFO head entry (combinational from FIFO memory).
- rinc  out  1  pop strobe to FIFO; the entry is consumed on the rclk edge where rinc=1.
- flush  in  1  single-cycle pulse: emit the partially packed word.
- out_data  out  DSIZE*OUT_BYTES  packed word; entry k at bits [k*DSIZE +: DSIZE].
- out_keep  out  OUT_BYTES  entry-valid mask, contiguous from bit 0.
- out_last  out  1  word was produced by a flush.
- out_valid  out  1  out_* stable while out_valid=1 and out_ready=0.
- out_ready  in  1  downstream accept.
- busy  out  1  pack index nonzero or out_valid=1.

Behaviour:
- Reset (async assert, sync deassert by source): out_valid=0, out_data=0, out_keep=0, out_last=0, idx=0, flush_pend=0, state=IDLE. rinc=0 while rrst_n=0.
- Storage: pack register (OUT_BYTES entries), index idx, and a one-entry output register.
- Output slot free: out_valid=0, or out_ready=1 in the same cycle.
- rinc = !rempty && (idx != OUT_BYTES-1 || slot_free). Purely combinational; no pop while empty.
- Pop: rdata is written to pack slot idx and idx increments.
  - If idx was OUT_BYTES-1, the full word, keep all-ones and out_last=0 load into the output register on the same edge, and idx returns to 0.
  - Latency is 1 cycle from the final pop to out_valid=1.
- Throughput: one entry per cycle when the FIFO is non-empty and the sink is always ready. No bubble at word boundaries.
- States:
  - IDLE (idx=0, no pending flush).
  - FILL (idx>0).
  - FLUSH (flush_pend=1, waiting for a free output slot).
- Transitions:
  - IDLE->FILL on a pop.
  - FILL->IDLE when a word completes.
  - FILL->FLUSH on flush.
  - FLUSH->IDLE when the partial word loads.
- Flush rules:
  - flush in IDLE is ignored (no empty word). flush in FLUSH is ignored (already pending).
  - In FLUSH: rinc=0. The partial word loads with keep=(1<<idx)-1, out_last=1, unused entries zero. Then idx=0.
  - Flush in the same cycle as a pop: the popped entry is included first. If that pop completes the word, the full word is emitted with out_last=1 and no extra partial word follows.
- Output handshake: out_valid drops the cycle after out_valid&&out_ready unless a new word loads on that edge (back-to-back allowed).
- Reset mid-operation: all partial data is discarded and no word is emitted. The FIFO entry popped on the reset edge is lost, which is acceptable.
- Widths: idx wraps only via explicit reset to 0, never by modulo overflow.

Optional Feature:
- Macro: FIFO_RD_PACKER_CNT_EN.
- Defined: adds output port pop_cnt [31:0].
  - Counts entries popped (rinc=1 edges); wraps at 2^32.
  - Resets to 0.
  - Adds input cnt_clr, a synchronous clear; a pop in the same cycle as cnt_clr gives pop_cnt=1.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package fifo_rd_pkg:
  - state enum (IDLE, FILL, FLUSH).
  - default DSIZE/OUT_BYTES constants.
  - function keep_mask(idx).
- Natural sub-module: fifo_rd_outreg, a one-entry valid/ready output register holding data/keep/last. It instantiates cleanly under the top.

Test Plan:
- FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> rinc high 4 cycles; one word 0x44332211, keep=4'hF, last=0, out_valid 1 cycle after the 4th pop.
- 8 entries 0x01..0x08, out_ready held 0 -> 4 pops, then 3 more pops, then rinc=0. Releasing out_ready -> 0x04030201, then 0x08070605 back-to-back.
- Pop 0xAA,0xBB then flush -> word 0x0000BBAA, keep=4'b0011, last=1; busy=0 afterwards.
- Flush with idx=0 and FIFO empty -> no out_valid, rinc stays 0.
- Flush coincident with the 4th pop (entries 1..4) -> single word 0x04030201, keep=4'hF, last=1; no second word.
- Assert rrst_n=0 with idx=2 and out_valid=1 -> out_valid=0, keep=0, and after release the next 4 pops form a fresh aligned word. With FIFO_RD_PACKER_CNT_EN defined, pop_cnt=0 after reset and equals the number of rinc edges after 7 pops.
